multicycle_control_unit: RTL and testbench

Multicycle MIPS main controller: a Moore FSM that sequences instruction fetch, decode, execute, memory and write-back over several clocks. It replaces the single-cycle opcode decoder in front of the shared-memory multicycle datapath. Additions over the single-cycle decoder:
- memory ready/wait handshake with a timeout;
- addi and j support;
- illegal-opcode and bus-error fault state;
- retired-instruction counter.

---
 rtl/multicycle_control_unit_if.sv | 41 ++++
 rtl/multicycle_control_unit.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath/memory (slave).
// Memory handshake: mem_read/mem_write are the request (valid), held stable until the cycle mem_ready=1; that cycle completes the access.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic [5:0]       instr_op;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             retire;
  logic [CNT_W-1:0] instr_count;
  logic             illegal_op;
  logic             bus_err;

  modport master (
    input  en, instr_op, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, retire, instr_count, illegal_op, bus_err
  );

  modport slave (
    output en, instr_op, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, retire, instr_count, illegal_op, bus_err
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main controller: Moore FSM over fetch/decode/execute/memory/write-back,
// with memory wait timeout, sticky fault flags and a retired-instruction counter.
module multicycle_control_unit #(
  parameter logic [5:0] OP_RTYPE    = 6'b000000,
  parameter logic [5:0] OP_LW       = 6'b100011,
  parameter logic [5:0] OP_SW       = 6'b101011,
  parameter logic [5:0] OP_BEQ      = 6'b000100,
  parameter logic [5:0] OP_ADDI     = 6'b001000,
  parameter logic [5:0] OP_J        = 6'b000010,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 32
) (
  input logic                        clk,
  input logic                        rst_n,
  multicycle_control_unit_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_JUMP     = 4'd12,
    S_FAULT    = 4'd13
  } state_e;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e            state_q, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  count_q;
  logic              illegal_q, bus_err_q;
  logic              set_illegal, set_bus_err;
  logic              in_mem_state, timeout_hit;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Completion on the final allowed cycle beats the timeout because mem_ready is part of the test.
  assign timeout_hit  = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                        (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next  = state_q;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state_q)
      S_IDLE:     if (bus.en) state_next = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) state_next = S_DECODE;
        else if (timeout_hit) begin
          state_next  = S_FAULT;
          set_bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        if ((bus.instr_op == OP_LW) || (bus.instr_op == OP_SW)) state_next = S_MEM_ADDR;
        else if (bus.instr_op == OP_RTYPE) state_next = S_EXEC;
        else if (bus.instr_op == OP_BEQ)   state_next = S_BRANCH;
        else if (bus.instr_op == OP_ADDI)  state_next = S_ADDI_EX;
        else if (bus.instr_op == OP_J)     state_next = S_JUMP;
        else begin
          state_next  = S_FAULT;
          set_illegal = 1'b1;
        end
      end
      S_MEM_ADDR: state_next = (bus.instr_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ready) state_next = S_MEM_WB;
        else if (timeout_hit) begin
          state_next  = S_FAULT;
          set_bus_err = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (bus.mem_ready) state_next = bus.en ? S_FETCH : S_IDLE;
        else if (timeout_hit) begin
          state_next  = S_FAULT;
          set_bus_err = 1'b1;
        end
      end
      S_EXEC:     state_next = S_R_WB;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP:
                  state_next = bus.en ? S_FETCH : S_IDLE;
      S_FAULT:    state_next = S_FAULT;
      default:    state_next = S_IDLE;
    endcase
  end

  // Output decode from the registered state (FETCH additionally gates ir/pc write with mem_ready)
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.retire        = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE:   bus.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.retire     = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        bus.retire    = bus.mem_ready;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      S_R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        bus.retire    = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.retire        = 1'b1;
      end
      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        bus.retire    = 1'b1;
      end
      default: ;
    endcase
  end

  // Wait counter restarts whenever the FSM moves, so each memory state begins at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            wait_cnt <= '0;
    else if (state_next != state_q)        wait_cnt <= '0;
    else if (in_mem_state && !bus.mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (bus.retire) count_q <= count_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  assign bus.state       = state_q;
  assign bus.instr_count = count_q;
  assign bus.illegal_op  = illegal_q;
  assign bus.bus_err     = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected state/control vectors are queued
// as stimulus is planned and popped by a negedge scoreboard; tasks check counters and flags.
module tb_multicycle_control_unit;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 16;
  localparam int VW          = 21;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                         S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_EXEC = 4'd7,
                         S_R_WB = 4'd8, S_BRANCH = 4'd9, S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11,
                         S_JUMP = 4'd12, S_FAULT = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BAD = 6'b111111;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [VW-1:0]    exp_q[$];
  logic [VW-1:0]    mon_exp;
  logic [VW-1:0]    dut_vec;
  logic [CNT_W-1:0] exp_cnt;
  logic             sb_on = 1'b0;
  int               chk_cnt = 0;
  int               pass_cnt = 0;
  int               retire_seen = 0;

  assign dut_vec = {bus.state, bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.i_or_d,
                    bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                    bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source, bus.retire};

  // Expected {state, controls, retire} for one cycle, straight from the state table.
  function automatic logic [VW-1:0] exp_vec(input logic [3:0] st, input logic mr);
    logic pw, pwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa, ret;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa, ret} = '0;
    {asb, aop, psrc} = '0;
    case (st)
      S_FETCH:    begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      S_DECODE:   asb = 2'b11;
      S_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      S_MEM_RD:   begin mrd = 1; iord = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; ret = 1; end
      S_MEM_WR:   begin mwr = 1; iord = 1; ret = mr; end
      S_EXEC:     begin asa = 1; aop = 2'b10; end
      S_R_WB:     begin rw = 1; rdst = 1; ret = 1; end
      S_BRANCH:   begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; ret = 1; end
      S_ADDI_EX:  begin asa = 1; asb = 2'b10; end
      S_ADDI_WB:  begin rw = 1; ret = 1; end
      S_JUMP:     begin pw = 1; psrc = 2'b10; ret = 1; end
      default: ;
    endcase
    return {st, pw, pwc, irw, iord, mrd, mwr, m2r, rdst, rw, asa, asb, aop, psrc, ret};
  endfunction

  // Scoreboard: one expected vector per cycle while enabled
  always @(negedge clk) begin
    if (sb_on) begin
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_underflow: got %h, required a queued expectation", dut_vec);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dut_vec !== mon_exp)
          $display("FAIL sb_cycle t=%0t: got %h required %h", $time, dut_vec, mon_exp);
        else
          pass_cnt++;
      end
    end
    if (rst_n && bus.retire === 1'b1) retire_seen++;
  end

  // Driver: apply inputs for one cycle, return just after the next rising edge
  task automatic drive(input logic e, input logic [5:0] op, input logic mr);
    bus.en        = e;
    bus.instr_op  = op;
    bus.mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.instr_op = '0; bus.mem_ready = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Plans one instruction's cycle-by-cycle states, queues expectations, then drives it.
  task automatic run_instr(input logic [5:0] op, input int fetch_waits, input int data_waits,
                           input logic en_val, input logic from_idle);
    logic [3:0] st[$];
    logic       mrq[$];
    if (from_idle) begin st.push_back(S_IDLE); mrq.push_back(1'b0); end
    repeat (fetch_waits) begin st.push_back(S_FETCH); mrq.push_back(1'b0); end
    st.push_back(S_FETCH);  mrq.push_back(1'b1);
    st.push_back(S_DECODE); mrq.push_back(1'b1);
    case (op)
      OP_LW: begin
        st.push_back(S_MEM_ADDR); mrq.push_back(1'b1);
        repeat (data_waits) begin st.push_back(S_MEM_RD); mrq.push_back(1'b0); end
        st.push_back(S_MEM_RD); mrq.push_back(1'b1);
        st.push_back(S_MEM_WB); mrq.push_back(1'b1);
      end
      OP_SW: begin
        st.push_back(S_MEM_ADDR); mrq.push_back(1'b1);
        repeat (data_waits) begin st.push_back(S_MEM_WR); mrq.push_back(1'b0); end
        st.push_back(S_MEM_WR); mrq.push_back(1'b1);
      end
      OP_RTYPE: begin st.push_back(S_EXEC); mrq.push_back(1'b1);
                      st.push_back(S_R_WB); mrq.push_back(1'b1); end
      OP_BEQ:   begin st.push_back(S_BRANCH); mrq.push_back(1'b1); end
      OP_ADDI:  begin st.push_back(S_ADDI_EX); mrq.push_back(1'b1);
                      st.push_back(S_ADDI_WB); mrq.push_back(1'b1); end
      default:  begin st.push_back(S_JUMP); mrq.push_back(1'b1); end
    endcase
    foreach (st[i]) exp_q.push_back(exp_vec(st[i], mrq[i]));
    sb_on = 1'b1;
    foreach (st[i]) drive((from_idle && i == 0) ? 1'b1 : en_val, op, mrq[i]);
    sb_on = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (dut_vec !== exp_vec(S_IDLE, 1'b0) || bus.instr_count !== '0 ||
        bus.illegal_op !== 1'b0 || bus.bus_err !== 1'b0)
      $display("FAIL reset_state: got vec=%h cnt=%0d ill=%b berr=%b required vec=%h cnt=0 ill=0 berr=0",
               dut_vec, bus.instr_count, bus.illegal_op, bus.bus_err, exp_vec(S_IDLE, 1'b0));
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // en=0 keeps the FSM idle
    exp_q.push_back(exp_vec(S_IDLE, 1'b0));
    exp_q.push_back(exp_vec(S_IDLE, 1'b0));
    sb_on = 1'b1;
    drive(1'b0, OP_RTYPE, 1'b1);
    drive(1'b0, OP_RTYPE, 1'b1);
    sb_on = 1'b0;
  endtask

  task automatic test_rtype();
    int r0;
    r0 = retire_seen;
    run_instr(OP_RTYPE, 0, 0, 1'b0, 1'b1);
    chk_cnt++;
    if (bus.instr_count !== exp_cnt || retire_seen != r0 + 1)
      $display("FAIL rtype_count: got cnt=%0d retires=%0d required cnt=%0d retires=%0d",
               bus.instr_count, retire_seen - r0, exp_cnt, 1);
    else pass_cnt++;
  endtask

  task automatic test_lw_sw();
    int r0;
    r0 = retire_seen;
    run_instr(OP_LW, 0, 3, 1'b1, 1'b1);
    run_instr(OP_SW, 0, 3, 1'b0, 1'b0);
    chk_cnt++;
    if (bus.instr_count !== exp_cnt || retire_seen != r0 + 2)
      $display("FAIL lw_sw_count: got cnt=%0d retires=%0d required cnt=%0d retires=2",
               bus.instr_count, retire_seen - r0, exp_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (bus.state !== S_IDLE)
      $display("FAIL lw_sw_idle: got state=%0d required %0d", bus.state, S_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_beq_j();
    run_instr(OP_BEQ, 1, 0, 1'b1, 1'b1);
    run_instr(OP_J, 0, 0, 1'b0, 1'b0);
    chk_cnt++;
    if (bus.instr_count !== exp_cnt)
      $display("FAIL beq_j_count: got %0d required %0d", bus.instr_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    exp_q.push_back(exp_vec(S_IDLE, 1'b0));
    exp_q.push_back(exp_vec(S_FETCH, 1'b1));
    exp_q.push_back(exp_vec(S_DECODE, 1'b1));
    repeat (20) exp_q.push_back(exp_vec(S_FAULT, 1'b1));
    sb_on = 1'b1;
    drive(1'b1, OP_BAD, 1'b0);
    drive(1'b1, OP_BAD, 1'b1);
    drive(1'b1, OP_BAD, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    sb_on = 1'b0;
    chk_cnt++;
    if (bus.illegal_op !== 1'b1 || bus.bus_err !== 1'b0 || bus.instr_count !== exp_cnt)
      $display("FAIL illegal_flags: got ill=%b berr=%b cnt=%0d required ill=1 berr=0 cnt=%0d",
               bus.illegal_op, bus.bus_err, bus.instr_count, exp_cnt);
    else pass_cnt++;
    // asynchronous reset clears the fault immediately
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.state !== S_IDLE || bus.illegal_op !== 1'b0 || bus.instr_count !== '0)
      $display("FAIL illegal_reset: got state=%0d ill=%b cnt=%0d required state=0 ill=0 cnt=0",
               bus.state, bus.illegal_op, bus.instr_count);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_timeout();
    exp_q.push_back(exp_vec(S_IDLE, 1'b0));
    repeat (MEM_TIMEOUT) exp_q.push_back(exp_vec(S_FETCH, 1'b0));
    repeat (3) exp_q.push_back(exp_vec(S_FAULT, 1'b0));
    sb_on = 1'b1;
    drive(1'b1, OP_RTYPE, 1'b0);
    repeat (MEM_TIMEOUT + 3) drive(1'b1, OP_RTYPE, 1'b0);
    sb_on = 1'b0;
    chk_cnt++;
    if (bus.bus_err !== 1'b1 || bus.illegal_op !== 1'b0)
      $display("FAIL timeout_flags: got berr=%b ill=%b required berr=1 ill=0",
               bus.bus_err, bus.illegal_op);
    else pass_cnt++;
    do_reset();
    // ready on the last allowed cycle completes the fetch
    run_instr(OP_RTYPE, MEM_TIMEOUT - 1, 0, 1'b0, 1'b1);
    chk_cnt++;
    if (bus.bus_err !== 1'b0 || bus.instr_count !== exp_cnt)
      $display("FAIL timeout_edge: got berr=%b cnt=%0d required berr=0 cnt=%0d",
               bus.bus_err, bus.instr_count, exp_cnt);
    else pass_cnt++;
    // data-side timeout on a store
    exp_q.push_back(exp_vec(S_IDLE, 1'b0));
    exp_q.push_back(exp_vec(S_FETCH, 1'b1));
    exp_q.push_back(exp_vec(S_DECODE, 1'b1));
    exp_q.push_back(exp_vec(S_MEM_ADDR, 1'b1));
    repeat (MEM_TIMEOUT) exp_q.push_back(exp_vec(S_MEM_WR, 1'b0));
    exp_q.push_back(exp_vec(S_FAULT, 1'b0));
    sb_on = 1'b1;
    drive(1'b1, OP_SW, 1'b0);
    drive(1'b1, OP_SW, 1'b1);
    drive(1'b1, OP_SW, 1'b1);
    repeat (MEM_TIMEOUT + 2) drive(1'b1, OP_SW, 1'b0);
    sb_on = 1'b0;
    chk_cnt++;
    if (bus.bus_err !== 1'b1 || bus.instr_count !== exp_cnt)
      $display("FAIL sw_timeout: got berr=%b cnt=%0d required berr=1 cnt=%0d",
               bus.bus_err, bus.instr_count, exp_cnt);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = retire_seen;
    exp_q.push_back(exp_vec(S_IDLE, 1'b0));
    exp_q.push_back(exp_vec(S_FETCH, 1'b1));
    exp_q.push_back(exp_vec(S_DECODE, 1'b1));
    exp_q.push_back(exp_vec(S_MEM_ADDR, 1'b1));
    exp_q.push_back(exp_vec(S_MEM_RD, 1'b0));
    sb_on = 1'b1;
    drive(1'b1, OP_LW, 1'b0);
    drive(1'b1, OP_LW, 1'b1);
    drive(1'b1, OP_LW, 1'b1);
    drive(1'b1, OP_LW, 1'b1);
    drive(1'b1, OP_LW, 1'b0);
    sb_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.state !== S_IDLE || bus.instr_count !== '0 || retire_seen != r0)
      $display("FAIL reset_mid: got state=%0d cnt=%0d retires=%0d required state=0 cnt=0 retires=0",
               bus.state, bus.instr_count, retire_seen - r0);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 17; i++)
      run_instr(OP_ADDI, $urandom_range(0, 2), 0, (i == 16) ? 1'b0 : 1'b1, (i == 0) ? 1'b1 : 1'b0);
    chk_cnt++;
    if (bus.instr_count !== 4'd1)
      $display("FAIL b2b_wrap: got cnt=%0d required 1", bus.instr_count);
    else pass_cnt++;
    exp_q.push_back(exp_vec(S_IDLE, 1'b0));
    sb_on = 1'b1;
    drive(1'b0, OP_ADDI, 1'b1);
    sb_on = 1'b0;
    chk_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL sb_leftover: got %0d entries required 0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    bus.en = 1'b0; bus.instr_op = '0; bus.mem_ready = 1'b0;
    exp_cnt = '0;
    test_reset();
    test_rtype();
    test_lw_sw();
    test_beq_j();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
